// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default oversampling ratio and
// the data-bit-count decode used by both the transmitter and the receiver.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // 2'b00..2'b11 selects 5..8 data bits
  function automatic logic [3:0] data_bits(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over the low N data bits (N = 5..8); odd type inverts
// the even-parity result. Shared by the UART transmitter and receiver.
module uart_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] i_data,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_parity_type,
  output logic       o_parity
);

  logic [3:0] w_count;
  logic [7:0] w_masked;

  assign w_count = data_bits(i_num_bit_data);

  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign w_masked[gi] = i_data[gi] & (4'(gi) < w_count);
  end

  assign o_parity = (^w_masked) ^ i_parity_type;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits LSB-first, optional parity, 1 or 2
// stop bits, every bit OVERSAMPLE tx_tick pulses long. UART_TX_PARITY_EN compiles in parity.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_tick,
  input  logic       i_tx_start,
  input  logic [7:0] i_data,
  input  logic [1:0] i_num_bit_data,
  input  logic       i_stop_bit,
  input  logic       i_parity_en,
  input  logic       i_parity_type,
  output logic       o_tx_serial,
  output logic       o_tx_busy,
  output logic       o_tx_done
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  uart_state_t r_state, w_state_next;
  logic [7:0]  r_data;
  logic [1:0]  r_num_bits;
  logic        r_stop2;
  logic [3:0]  r_tick_cnt, w_tick_cnt_next;
  logic [2:0]  r_bit_idx, w_bit_idx_next;
  logic        r_stop_cnt, w_stop_cnt_next;
  logic        r_serial, w_serial_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic        w_accept;
  logic        w_bit_end;
  logic [2:0]  w_last_idx;
  logic [2:0]  w_idx_inc;

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_type;
  logic w_parity;

  uart_parity_gen u_parity_gen (
    .i_data         (r_data),
    .i_num_bit_data (r_num_bits),
    .i_parity_type  (r_par_type),
    .o_parity       (w_parity)
  );
`else
  logic w_unused_parity_cfg;
  assign w_unused_parity_cfg = i_parity_en ^ i_parity_type;
`endif

  // Busy doubles as "request pending" while IDLE waits for tick alignment
  assign w_accept   = (r_state == IDLE) && !r_busy && i_tx_start;
  assign w_bit_end  = tx_tick && (r_tick_cnt == TICK_LAST);
  assign w_last_idx = 3'(data_bits(r_num_bits) - 4'd1);
  assign w_idx_inc  = r_bit_idx + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_num_bits <= '0;
      r_stop2    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_type <= 1'b0;
`endif
    end else if (w_accept) begin
      r_data     <= i_data;
      r_num_bits <= i_num_bit_data;
      r_stop2    <= i_stop_bit;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= i_parity_en;
      r_par_type <= i_parity_type;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_stop_cnt <= 1'b0;
      r_serial   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_serial   <= w_serial_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_stop_cnt_next = r_stop_cnt;
    w_serial_next   = r_serial;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;

    if (r_state != IDLE && tx_tick) begin
      w_tick_cnt_next = w_bit_end ? 4'd0 : r_tick_cnt + 4'd1;
    end

    case (r_state)
      IDLE: begin
        w_serial_next = 1'b1;
        if (w_accept) begin
          w_busy_next = 1'b1;
        end else if (r_busy && tx_tick) begin
          w_state_next    = START;
          w_serial_next   = 1'b0;
          w_tick_cnt_next = 4'd0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next   = DATA;
          w_bit_idx_next = 3'd0;
          w_serial_next  = r_data[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == w_last_idx) begin
            w_state_next    = STOP;
            w_serial_next   = 1'b1;
            w_stop_cnt_next = 1'b0;
`ifdef UART_TX_PARITY_EN
            if (r_par_en) begin
              w_state_next  = PARITY;
              w_serial_next = w_parity;
            end
`endif
          end else begin
            w_bit_idx_next = w_idx_inc;
            w_serial_next  = r_data[w_idx_inc];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_next    = STOP;
          w_serial_next   = 1'b1;
          w_stop_cnt_next = 1'b0;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_cnt_next = 1'b1;
          end else begin
            w_state_next    = IDLE;
            w_stop_cnt_next = 1'b0;
            w_busy_next     = 1'b0;
            w_done_next     = 1'b1;
            w_serial_next   = 1'b1;
          end
        end
      end
      default: begin
        w_state_next  = IDLE;
        w_serial_next = 1'b1;
        w_busy_next   = 1'b0;
      end
    endcase
  end

  assign o_tx_serial = r_serial;
  assign o_tx_busy   = r_busy;
  assign o_tx_done   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: each frame is compared, bit by bit and cycle by
// cycle, against an ideal frame built from the data and configuration.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int OS     = 16;
  localparam int BUDGET = 4000;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_tick = 1'b0;
  logic       i_tx_start = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic [1:0] i_num_bit_data = 2'b00;
  logic       i_stop_bit = 1'b0;
  logic       i_parity_en = 1'b0;
  logic       i_parity_type = 1'b0;
  logic       o_tx_serial;
  logic       o_tx_busy;
  logic       o_tx_done;

  int n_cmp = 0;
  int n_err = 0;
  bit tick_en = 1'b1;
  bit exp_bits[$];

  uart_tx #(.OVERSAMPLE(OS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tx_tick        (tx_tick),
    .i_tx_start     (i_tx_start),
    .i_data         (i_data),
    .i_num_bit_data (i_num_bit_data),
    .i_stop_bit     (i_stop_bit),
    .i_parity_en    (i_parity_en),
    .i_parity_type  (i_parity_type),
    .o_tx_serial    (o_tx_serial),
    .o_tx_busy      (o_tx_busy),
    .o_tx_done      (o_tx_done)
  );

  always #5 clk = ~clk;

  // Irregular tick pattern: roughly one tick every three clocks
  always @(negedge clk) tx_tick = tick_en && ($urandom_range(0, 2) == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Ideal frame as a list of line levels, one entry per bit period
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] nb,
                                      input bit st, input bit pe, input bit pt);
    int n = int'(nb) + 5;
    int ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe && PAR_BUILT) exp_bits.push_back(((ones % 2) == 1) ^ pt);
    exp_bits.push_back(1'b1);
    if (st) exp_bits.push_back(1'b1);
  endfunction

  task automatic start_req(input string name, input logic [7:0] d, input logic [1:0] nb,
                           input bit st, input bit pe, input bit pt);
    check({name, ":busy_pre"}, 32'(o_tx_busy), 0);
    i_data = d;
    i_num_bit_data = nb;
    i_stop_bit = st;
    i_parity_en = pe;
    i_parity_type = pt;
    i_tx_start = 1'b1;
    @(posedge clk);
    #1;
    i_tx_start = 1'b0;
    check({name, ":busy_rise"}, 32'(o_tx_busy), 1);
    check({name, ":line_held"}, 32'(o_tx_serial), 1);
    build_frame(d, nb, st, pe, pt);
    // Scramble the live inputs: the frame in flight must not see them
    i_data = 8'($urandom);
    i_num_bit_data = 2'($urandom);
    i_stop_bit = 1'($urandom);
    i_parity_en = 1'($urandom);
    i_parity_type = 1'($urandom);
  endtask

  task automatic watch_frame(input string name, input int rst_bit, input bit poke, input bit stall);
    int  n_ticks = 0;
    int  cyc = 0;
    int  bit_i = 0;
    int  stall_left = 0;
    int  s0 = 0;
    int  s1 = 0;
    int  total;
    bit  bad_ctl = 1'b0;
    bit  fell = 1'b0;
    bit  t;
    total = exp_bits.size() * OS;
    while (!fell) begin
      @(posedge clk);
      t = tx_tick;
      #1;
      cyc++;
      if (t) begin
        check({name, ":fall"}, 32'(o_tx_serial), 0);
        fell = 1'b1;
        if (o_tx_serial === 1'b0) s0 = 1; else s1 = 1;
      end else if (o_tx_serial !== 1'b1 || o_tx_busy !== 1'b1 || o_tx_done !== 1'b0) begin
        bad_ctl = 1'b1;
      end
      if (cyc > BUDGET) begin
        check({name, ":timeout_fall"}, cyc, BUDGET);
        return;
      end
    end
    while (n_ticks < total) begin
      @(posedge clk);
      t = tx_tick;
      #1;
      cyc++;
      i_tx_start = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) tick_en = 1'b1;
      end
      if (t) begin
        n_ticks++;
        if (n_ticks % OS == 0) begin
          check($sformatf("%s:bit%0d", name, bit_i),
                (s0 > 0 && s1 > 0) ? 32'd2 : ((s1 > 0) ? 32'd1 : 32'd0),
                32'(exp_bits[bit_i]));
          bit_i++;
          s0 = 0;
          s1 = 0;
        end
      end
      if (n_ticks == total) break;
      if (o_tx_serial === 1'b1) s1++;
      else if (o_tx_serial === 1'b0) s0++;
      else begin s0++; s1++; end
      if (o_tx_done !== 1'b0 || o_tx_busy !== 1'b1) bad_ctl = 1'b1;
      if (poke && t && n_ticks == 40) i_tx_start = 1'b1;
      if (stall && t && n_ticks == 35) begin
        tick_en = 1'b0;
        stall_left = 300;
      end
      if (rst_bit >= 0 && bit_i == rst_bit && t && (n_ticks % OS) == 6) begin
        rst_n = 1'b0;
        #1;
        check({name, ":rst_line"}, 32'(o_tx_serial), 1);
        check({name, ":rst_busy"}, 32'(o_tx_busy), 0);
        repeat (20) begin
          @(posedge clk);
          #1;
          if (o_tx_done !== 1'b0 || o_tx_serial !== 1'b1 || o_tx_busy !== 1'b0) bad_ctl = 1'b1;
        end
        check({name, ":rst_ctl"}, 32'(bad_ctl), 0);
        rst_n = 1'b1;
        return;
      end
      if (cyc > BUDGET + 400) begin
        check({name, ":timeout_frame"}, cyc, BUDGET + 400);
        tick_en = 1'b1;
        return;
      end
    end
    check({name, ":done"}, 32'(o_tx_done), 1);
    check({name, ":busy_end"}, 32'(o_tx_busy), 0);
    check({name, ":line_end"}, 32'(o_tx_serial), 1);
    check({name, ":ctl"}, 32'(bad_ctl), 0);
  endtask

  task automatic idle_check(input string name, input int ncyc);
    bit bad = 1'b0;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      if (o_tx_done !== 1'b0 || o_tx_busy !== 1'b0 || o_tx_serial !== 1'b1) bad = 1'b1;
    end
    check({name, ":idle"}, 32'(bad), 0);
  endtask

  task automatic frame(input string name, input logic [7:0] d, input logic [1:0] nb,
                       input bit st, input bit pe, input bit pt,
                       input int rst_bit, input bit poke, input bit stall, input bit b2b);
    $display("frame %-10s data=%02h bits=%0d stop=%0d par_en=%0d par_odd=%0d b2b=%0d",
             name, d, int'(nb) + 5, int'(st) + 1, pe, pt, b2b);
    start_req(name, d, nb, st, pe, pt);
    watch_frame(name, rst_bit, poke, stall);
    if (!b2b) idle_check(name, 40);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_serial", 32'(o_tx_serial), 1);
    check("rst_busy", 32'(o_tx_busy), 0);
    check("rst_done", 32'(o_tx_done), 0);
    rst_n = 1'b1;
    idle_check("post_rst", 10);

    frame("a5_8n1",  8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    frame("1f_5e2",  8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    frame("e3_5n1",  8'hE3, 2'b00, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    frame("00_8o1",  8'h00, 2'b11, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    frame("ff_8e1",  8'hFF, 2'b11, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    frame("3c_poke", 8'h3C, 2'b10, 1'b0, 1'b1, 1'b0, -1, 1'b1, 1'b0, 1'b1);
    frame("c3_b2b",  8'hC3, 2'b11, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    frame("5a_rst",  8'h5A, 2'b11, 1'b0, 1'b0, 1'b0,  4, 1'b0, 1'b0, 1'b0);
    frame("96_stall", 8'h96, 2'b01, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      frame($sformatf("rnd%0d", i), 8'($urandom), 2'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), -1, 1'b0, 1'b0,
            (i < 15) && ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART serial transmitter: the transmit-side counterpart of `uart_rx`, using the same frame-configuration inputs and the same 16× oversampling tick. It accepts one parallel byte per request and serialises it LSB-first as a frame:

- start bit;
- 5–8 data bits;
- optional even/odd parity bit;
- 1 or 2 stop bits.

It sits between the host/register interface and the TX pin. The shared baud-tick generator drives `tx_tick`.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `tx_tick` pulses per bit period.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `tx_tick`  in  1: one-`clk` baud pulse at 16× the bit rate.
- `i_tx_start`  in  1: transmit request, sampled at posedge `clk`.
- `i_data`  in  8: payload; only the low N bits are sent.
- `i_num_bit_data`  in  2: data-bit count. `00`=5, `01`=6, `10`=7, `11`=8.
- `i_stop_bit`  in  1: `0` = 1 stop bit, `1` = 2 stop bits.
- `i_parity_en`  in  1: `1` inserts a parity bit.
- `i_parity_type`  in  1: `0` = even, `1` = odd.
- `o_tx_serial`  out  1: serial line; idles high.
- `o_tx_busy`  out  1: high from request accept until the frame completes.
- `o_tx_done`  out  1: one-`clk` pulse at the end of the last stop bit.

## Operation
- States: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4. These are the same encodings as the receiver.
- **IDLE**
  - `o_tx_serial`=1.
  - When `i_tx_start`=1, latch `i_data`, the bit count, stop mode, parity enable and parity type into shadow registers, and set the busy flag.
  - Then wait for the next `tx_tick` and enter START on that edge. Every bit therefore starts tick-aligned.
- **START**
  - Line is 0 for exactly `OVERSAMPLE` ticks.
  - Then go to DATA with bit index 0.
- **DATA**
  - Line is `data_q[idx]` for `OVERSAMPLE` ticks per bit.
  - After bit N-1, go to PARITY if parity is enabled, otherwise to STOP.
- **PARITY**
  - Line is the XOR of the N sent bits, inverted when odd parity is selected.
  - Held for `OVERSAMPLE` ticks, then go to STOP.
- **STOP**
  - Line is 1 for `OVERSAMPLE` ticks, or 2×`OVERSAMPLE` ticks when 2 stop bits are selected.
  - At the end: pulse `o_tx_done`, clear busy, return to IDLE.
- Tick counter:
  - 4 bits, counts `tx_tick` only, range 0..`OVERSAMPLE`-1.
  - Wraps to 0 at each bit boundary.
- Bit index:
  - 3 bits, range 0..N-1.
  - Stop-bit sub-counter: 1 bit.
- Configuration inputs are ignored after latch. Changing them mid-frame has no effect on the frame in progress.
- `i_tx_start` while busy is ignored, with no queueing.

## Timing
- Reset values (asynchronous, applied immediately): `o_tx_serial`=1, `o_tx_busy`=0, `o_tx_done`=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame, returns the line high, and produces no `o_tx_done`.
- All outputs are registered.
- `o_tx_busy` rises 1 `clk` after the accepting edge.
- `o_tx_serial` falls on the first `tx_tick` edge after accept. If `tx_tick` is high in the same cycle as the accept, the fall occurs on the next tick, not that one.
- Frame length in ticks is 16×(1 + N + P + S), where P = parity enabled (0/1) and S = stop bits (1/2). Example: 8N1 = 160 ticks.
- `o_tx_done` is high for the single `clk` cycle after the final stop-tick edge, while `o_tx_busy` is low.
- Back-to-back: `i_tx_start` asserted during the `o_tx_done` cycle is accepted. The next start bit begins on the following tick, with no idle gap beyond tick alignment.
- `tx_tick` held low stalls the frame indefinitely with the line held; this is not an error.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state and the parity generator are compiled in, and behaviour is as above.
- Undefined:
  - PARITY state and parity logic are removed.
  - `i_parity_en` and `i_parity_type` remain as ports but are ignored.
  - DATA goes directly to STOP, and frames are always 16×(1+N+S) ticks.

## Structure
- Shared package `uart_pkg`, used by both `uart_rx` and `uart_tx`:
  - state encodings IDLE..STOP;
  - `OVERSAMPLE` default;
  - a function that maps `i_num_bit_data` to the data-bit count (5..8).
- Sub-module `uart_parity_gen` (combinational): inputs are data[7:0], bit count and type; output is the parity bit. It is shared with `uart_rx` parity checking.

## Test plan
- **0xA5, 8N1** (`11`, parity off, 1 stop) → line 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks. `o_tx_done` fires once, 160 ticks after the fall.
- **0x1F, 5-bit, even parity, 2 stop** → data 1,1,1,1,1, parity 1, stop 1,1. Frame is 144 ticks. Bits 7:5 of `i_data` are not transmitted.
- **0x00, 8-bit, odd parity, 1 stop** → parity bit 1. **0xFF, 8-bit, even parity** → parity bit 0.
- **Second `i_tx_start` pulse while busy** → ignored: exactly one frame, one `o_tx_done`. **Start during the `o_tx_done` cycle** → the second frame follows immediately.
- **`rst_n` low during DATA bit 3** → `o_tx_serial`=1 and `o_tx_busy`=0 immediately, no `o_tx_done`. The next request after reset transmits correctly.
- **Loopback into `uart_rx`**: DIVISOR=325, 50 MHz `clk`, shared tick, 0x3C, 7-bit, even parity → `uart_rx` outputs `o_data`=0x3C with `o_parity_err`=0. The same test with `UART_TX_PARITY_EN` undefined and the receiver parity disabled passes too.
